// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core: sequences fetch/decode/execute/
// memory/writeback and drives datapath enables, mux selects, ALUOp and ImmSrc.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       Illegal
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_JAL      = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_pc_update;
  logic   w_branch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = S_FETCH;
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    AdrSrc      = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    RegWrite    = 1'b0;
    Illegal     = 1'b0;
    case (r_state)
      S_FETCH: begin
        // op is still loading into the IR here, so it must not steer anything
        IRWrite     = 1'b1;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        w_pc_update = 1'b1;
        w_next      = S_DECODE;
      end
      S_DECODE: begin
        // ALU precomputes OldPC + imm for a possible branch
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_JAL:       w_next = S_JAL;
          OP_BEQ:       w_next = S_BEQ;
          default: begin
            w_next  = S_FETCH;
            Illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        w_next  = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        w_next    = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b00;
        ALUOp   = 2'b10;
        w_next  = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        w_next  = S_ALUWB;
      end
      S_JAL: begin
        // PC <- branch target from Decode; ALU forms OldPC + 4 for the link
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        w_pc_update = 1'b1;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA  = 2'b10;
        ALUSrcB  = 2'b00;
        ALUOp    = 2'b01;
        w_branch = 1'b1;
        w_next   = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  assign PCWrite = w_pc_update | (w_branch & Zero);

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each opcode through its state
// sequence and compares the Moore output vector cycle by cycle.
module tb_multicycle_ctrl;

  logic       clk, reset, Zero;
  logic [6:0] op;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic [13:0] obs;
  int n_cmp = 0;
  int n_err = 0;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .Illegal(Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, RegWrite, Illegal}
  assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, RegWrite, Illegal};

  localparam logic [13:0] E_FETCH  = {1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
  localparam logic [13:0] E_DEC    = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0};
  localparam logic [13:0] E_DECILL = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b1};
  localparam logic [13:0] E_MEMADR = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0};
  localparam logic [13:0] E_MEMRD  = {1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [13:0] E_MEMWB  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
  localparam logic [13:0] E_MEMWR  = {1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [13:0] E_EXR    = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0};
  localparam logic [13:0] E_EXI    = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0, 1'b0};
  localparam logic [13:0] E_JAL    = {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0};
  localparam logic [13:0] E_ALUWB  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
  localparam logic [13:0] E_BEQ1   = {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, 1'b0};
  localparam logic [13:0] E_BEQ0   = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, 1'b0};

  task automatic test_reset();
    reset = 1'b1; op = 7'b0000000; Zero = 1'b0;
    #12;
    n_cmp++;
    if (obs !== E_FETCH) begin n_err++; $display("FAIL reset_hold obs=%b exp=%b", obs, E_FETCH); end
    n_cmp++;
    if (ImmSrc !== 2'b00) begin n_err++; $display("FAIL reset_immsrc got=%b exp=00", ImmSrc); end
    @(negedge clk); reset = 1'b0; #1;
    n_cmp++;
    if (obs !== E_FETCH) begin n_err++; $display("FAIL reset_release obs=%b exp=%b", obs, E_FETCH); end
  endtask

  task automatic test_lw();
    logic [13:0] exp [0:5];
    exp = '{E_FETCH, E_DEC, E_MEMADR, E_MEMRD, E_MEMWB, E_FETCH};
    op = 7'b0000011; Zero = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (obs !== exp[i]) begin n_err++; $display("FAIL lw_cyc%0d obs=%b exp=%b", i, obs, exp[i]); end
      if (i == 1) begin
        n_cmp++;
        if (ImmSrc !== 2'b00) begin n_err++; $display("FAIL lw_immsrc got=%b exp=00", ImmSrc); end
      end
      if (i < 5) begin @(negedge clk); #1; end
    end
  endtask

  task automatic test_sw();
    logic [13:0] exp [0:4];
    exp = '{E_FETCH, E_DEC, E_MEMADR, E_MEMWR, E_FETCH};
    op = 7'b0100011; Zero = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (obs !== exp[i]) begin n_err++; $display("FAIL sw_cyc%0d obs=%b exp=%b", i, obs, exp[i]); end
      if (i == 1) begin
        n_cmp++;
        if (ImmSrc !== 2'b01) begin n_err++; $display("FAIL sw_immsrc got=%b exp=01", ImmSrc); end
      end
      if (i < 4) begin @(negedge clk); #1; end
    end
  endtask

  task automatic test_alu();
    logic [13:0] exp [0:4];
    // R-type then I-type back to back; Zero held high to catch leakage into PCWrite
    for (int k = 0; k < 2; k++) begin
      exp = '{E_FETCH, E_DEC, (k == 0) ? E_EXR : E_EXI, E_ALUWB, E_FETCH};
      op = (k == 0) ? 7'b0110011 : 7'b0010011; Zero = 1'b1;
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (obs !== exp[i]) begin n_err++; $display("FAIL alu%0d_cyc%0d obs=%b exp=%b", k, i, obs, exp[i]); end
        if (i == 1) begin
          n_cmp++;
          if (ImmSrc !== 2'b00) begin n_err++; $display("FAIL alu%0d_immsrc got=%b exp=00", k, ImmSrc); end
        end
        if (i < 4) begin @(negedge clk); #1; end
      end
    end
  endtask

  task automatic test_beq();
    logic [13:0] exp [0:3];
    for (int z = 1; z >= 0; z--) begin
      exp = '{E_FETCH, E_DEC, (z == 1) ? E_BEQ1 : E_BEQ0, E_FETCH};
      op = 7'b1100011; Zero = (z == 1);
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (obs !== exp[i]) begin n_err++; $display("FAIL beq_z%0d_cyc%0d obs=%b exp=%b", z, i, obs, exp[i]); end
        if (i == 1) begin
          n_cmp++;
          if (ImmSrc !== 2'b10) begin n_err++; $display("FAIL beq_immsrc got=%b exp=10", ImmSrc); end
        end
        if (i < 3) begin @(negedge clk); #1; end
      end
    end
  endtask

  task automatic test_jal();
    logic [13:0] exp [0:4];
    exp = '{E_FETCH, E_DEC, E_JAL, E_ALUWB, E_FETCH};
    op = 7'b1101111; Zero = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (obs !== exp[i]) begin n_err++; $display("FAIL jal_cyc%0d obs=%b exp=%b", i, obs, exp[i]); end
      if (i == 1) begin
        n_cmp++;
        if (ImmSrc !== 2'b11) begin n_err++; $display("FAIL jal_immsrc got=%b exp=11", ImmSrc); end
      end
      if (i < 4) begin @(negedge clk); #1; end
    end
  endtask

  task automatic test_illegal();
    logic [13:0] exp [0:2];
    exp = '{E_FETCH, E_DECILL, E_FETCH};
    op = 7'b1111111; Zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (obs !== exp[i]) begin n_err++; $display("FAIL illegal_cyc%0d obs=%b exp=%b", i, obs, exp[i]); end
      if (i == 1) begin
        n_cmp++;
        if (ImmSrc !== 2'b00) begin n_err++; $display("FAIL illegal_immsrc got=%b exp=00", ImmSrc); end
      end
      if (i < 2) begin @(negedge clk); #1; end
    end
  endtask

  task automatic test_reset_mid_sw();
    logic [13:0] exp [0:2];
    exp = '{E_FETCH, E_DEC, E_MEMADR};
    op = 7'b0100011; Zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (obs !== exp[i]) begin n_err++; $display("FAIL rstsw_cyc%0d obs=%b exp=%b", i, obs, exp[i]); end
      if (i < 2) begin @(negedge clk); #1; end
    end
    // asynchronous: Fetch outputs must appear before any clock edge
    #1; reset = 1'b1; #1;
    n_cmp++;
    if (obs !== E_FETCH) begin n_err++; $display("FAIL rstsw_async obs=%b exp=%b", obs, E_FETCH); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (MemWrite !== 1'b0 || obs !== E_FETCH) begin
        n_err++; $display("FAIL rstsw_hold%0d obs=%b exp=%b", i, obs, E_FETCH);
      end
    end
    reset = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if (obs !== E_DEC) begin n_err++; $display("FAIL rstsw_first_edge obs=%b exp=%b", obs, E_DEC); end
    @(negedge clk); #1;
    @(negedge clk); #1;
    n_cmp++;
    if (obs !== E_MEMWR) begin n_err++; $display("FAIL rstsw_resume obs=%b exp=%b", obs, E_MEMWR); end
    @(negedge clk); #1;
    n_cmp++;
    if (obs !== E_FETCH) begin n_err++; $display("FAIL rstsw_end obs=%b exp=%b", obs, E_FETCH); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_alu();
    test_beq();
    test_jal();
    test_illegal();
    test_reset_mid_sw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
